// File: rtl/dual_issue_scoreboard.sv
// Dual-issue scoreboard: decides each cycle whether slot A, or slots A+B,
// may issue to the dual-port register file, tracks a busy bit per register
// for long-latency results, and counts stall cycles (saturating).
// Optional feature: define SB_WB_BYPASS_EN so that a writeback releases its
// dependents in the same cycle; otherwise release is one cycle later.
module dual_issue_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valA_i,
    input  logic                     valB_i,
    input  logic [ADDR_WIDTH-1:0]    rs1A_i,
    input  logic [ADDR_WIDTH-1:0]    rs2A_i,
    input  logic [ADDR_WIDTH-1:0]    rs1B_i,
    input  logic [ADDR_WIDTH-1:0]    rs2B_i,
    input  logic [ADDR_WIDTH-1:0]    rdA_i,
    input  logic [ADDR_WIDTH-1:0]    rdB_i,
    input  logic                     wrA_i,
    input  logic                     wrB_i,
    input  logic                     longA_i,
    input  logic                     longB_i,
    input  logic                     wbA_i,
    input  logic                     wbB_i,
    input  logic [ADDR_WIDTH-1:0]    wbRdA_i,
    input  logic [ADDR_WIDTH-1:0]    wbRdB_i,
    input  logic                     hold_i,
    output logic [1:0]               issue_o,
    output logic                     stall_o,
    output logic [2**ADDR_WIDTH-1:0] busy_o,
    output logic [CNT_WIDTH-1:0]     stall_cnt_o
);

    localparam int NREG = 2**ADDR_WIDTH;

    logic [NREG-1:0]      busy_q;
    logic [NREG-1:0]      clear_mask;
    logic [NREG-1:0]      set_mask;
    logic [NREG-1:0]      busy_eff;
    logic [NREG-1:0]      busy_nxt;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 haz_a;
    logic                 haz_b;
    logic                 raw_ab;
    logic                 waw_ab;
    logic                 issue_a;
    logic                 issue_b;
    logic                 stall;

    // Decode this cycle's writebacks into a per-register clear mask.
    always_comb begin
        clear_mask = '0;
        if (wbA_i) clear_mask[wbRdA_i] = 1'b1;
        if (wbB_i) clear_mask[wbRdB_i] = 1'b1;
    end

    // Busy view used by the hazard checks (optionally bypassing writebacks).
    always_comb begin
`ifdef SB_WB_BYPASS_EN
        busy_eff = busy_q & ~clear_mask;
`else
        busy_eff = busy_q;
`endif
    end

    // Issue decision: A on its own hazards, B additionally on intra-pair RAW/WAW.
    always_comb begin
        haz_a   = busy_eff[rs1A_i] | busy_eff[rs2A_i] | (wrA_i & busy_eff[rdA_i]);
        haz_b   = busy_eff[rs1B_i] | busy_eff[rs2B_i] | (wrB_i & busy_eff[rdB_i]);
        raw_ab  = wrA_i & (rdA_i != '0) & ((rs1B_i == rdA_i) | (rs2B_i == rdA_i));
        waw_ab  = wrA_i & wrB_i & (rdA_i == rdB_i) & (rdA_i != '0);
        issue_a = ~reset & valA_i & ~hold_i & ~haz_a;
        issue_b = issue_a & valB_i & ~haz_b & ~raw_ab & ~waw_ab;
        stall   = ~reset & valA_i & ~issue_a;
    end

    // Next busy vector: clears applied first so a same-cycle set wins; x0 never busy.
    always_comb begin
        set_mask = '0;
        if (issue_a & wrA_i & longA_i) set_mask[rdA_i] = 1'b1;
        if (issue_b & wrB_i & longB_i) set_mask[rdB_i] = 1'b1;
        busy_nxt    = (busy_q & ~clear_mask) | set_mask;
        busy_nxt[0] = 1'b0;
    end

    // Busy register; reset drops every outstanding long-latency result.
    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_nxt;
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (reset)                      cnt_q <= '0;
        else if (stall && cnt_q != '1)  cnt_q <= cnt_q + CNT_WIDTH'(1);
    end

    assign issue_o     = {issue_a, issue_b};
    assign stall_o     = stall;
    assign busy_o      = busy_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Self-checking bench for dual_issue_scoreboard: directed scenarios plus
// randomized traffic compared against a behavioural reference model.
module tb_dual_issue_scoreboard;

    localparam int AW   = 5;
    localparam int CW   = 16;
    localparam int NREG = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          valA, valB, wrA, wrB, longA, longB, wbA, wbB, hold;
    logic [AW-1:0] rs1A, rs2A, rs1B, rs2B, rdA, rdB, wbRdA, wbRdB;
    logic [1:0]    issue;
    logic          stall;
    logic [NREG-1:0] busy;
    logic [CW-1:0] cnt;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  chk_en   = 1'b1;

    // Reference model state
    bit  m_busy [NREG];
    int  m_cnt;

    dual_issue_scoreboard #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .valA_i(valA), .valB_i(valB),
        .rs1A_i(rs1A), .rs2A_i(rs2A), .rs1B_i(rs1B), .rs2B_i(rs2B),
        .rdA_i(rdA), .rdB_i(rdB), .wrA_i(wrA), .wrB_i(wrB),
        .longA_i(longA), .longB_i(longB),
        .wbA_i(wbA), .wbB_i(wbB), .wbRdA_i(wbRdA), .wbRdB_i(wbRdB),
        .hold_i(hold),
        .issue_o(issue), .stall_o(stall), .busy_o(busy), .stall_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_is_busy(int r);
        bit b;
        if (r == 0) return 1'b0;
        b = m_busy[r];
`ifdef SB_WB_BYPASS_EN
        if ((wbA && int'(wbRdA) == r) || (wbB && int'(wbRdB) == r)) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic bit m_issue_a();
        bit haz;
        haz = m_is_busy(rs1A) || m_is_busy(rs2A) || (wrA && m_is_busy(rdA));
        return !reset && valA && !hold && !haz;
    endfunction

    function automatic bit m_issue_b();
        bit haz, raw, waw;
        haz = m_is_busy(rs1B) || m_is_busy(rs2B) || (wrB && m_is_busy(rdB));
        raw = wrA && rdA != 0 && (rs1B == rdA || rs2B == rdA);
        waw = wrA && wrB && rdA == rdB && rdA != 0;
        return m_issue_a() && valB && !haz && !raw && !waw;
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v = '0;
        for (int r = 0; r < NREG; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic idle();
        valA = 0; valB = 0; wrA = 0; wrB = 0; longA = 0; longB = 0;
        wbA = 0; wbB = 0; hold = 0;
        rs1A = 0; rs2A = 0; rs1B = 0; rs2B = 0; rdA = 0; rdB = 0;
        wbRdA = 0; wbRdB = 0;
    endtask

    // One clock: compare outputs against the model, clock, then advance the model.
    task automatic step();
        bit ia, ib, st;
        #1;
        ia = m_issue_a();
        ib = m_issue_b();
        st = !reset && valA && !ia;
        if (chk_en) begin
            chk("issue", {30'd0, issue}, {30'd0, ia, ib});
            chk("stall", {31'd0, stall}, {31'd0, st});
            chk("busy",  busy, m_busy_vec());
            chk("cnt",   {16'd0, cnt}, m_cnt);
        end
        @(posedge clk);
        if (reset) begin
            foreach (m_busy[r]) m_busy[r] = 1'b0;
            m_cnt = 0;
        end else begin
            if (wbA) m_busy[wbRdA] = 1'b0;
            if (wbB) m_busy[wbRdB] = 1'b0;
            if (ia && wrA && longA && rdA != 0) m_busy[rdA] = 1'b1;
            if (ib && wrB && longB && rdB != 0) m_busy[rdB] = 1'b1;
            if (st && m_cnt < 65535) m_cnt++;
        end
        @(negedge clk);
    endtask

    initial begin
        foreach (m_busy[r]) m_busy[r] = 1'b0;
        m_cnt = 0;
        idle();
        reset = 1;
        @(negedge clk);
        // Outputs suppressed while in reset even with a valid slot A
        valA = 1;
        #1 chk("rst_issue", {30'd0, issue}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        step(); step();
        chk("rst_busy", busy, 32'd0);
        chk("rst_cnt", {16'd0, cnt}, 32'd0);
        reset = 0;

        // Long-latency producer into r3
        valA = 1; rs1A = 1; rs2A = 2; rdA = 3; wrA = 1; longA = 1;
        #1 chk("prod_issue", {30'd0, issue}, 32'h2);
        step();
        chk("prod_busy3", {31'd0, busy[3]}, 32'd1);

        // Dependent stalls until writeback
        idle(); valA = 1; rs1A = 3;
        #1 chk("dep_issue", {30'd0, issue}, 32'd0);
        chk("dep_stall", {31'd0, stall}, 32'd1);
        step(); step();
        chk("dep_cnt", {16'd0, cnt}, 32'd2);
        wbA = 1; wbRdA = 3;
`ifdef SB_WB_BYPASS_EN
        #1 chk("wb_cycle_issue", {30'd0, issue}, 32'h2);
`else
        #1 chk("wb_cycle_issue", {30'd0, issue}, 32'h0);
`endif
        step();
        wbA = 0;
        #1 chk("wb_next_issue", {30'd0, issue}, 32'h2);
        step();

        // Intra-pair RAW, and the x0 exception
        idle(); valA = 1; valB = 1; rdA = 5; wrA = 1; rs2B = 5;
        #1 chk("raw_issue", {30'd0, issue}, 32'h2);
        step();
        rdA = 0; rs2B = 0;
        #1 chk("raw_x0_issue", {30'd0, issue}, 32'h3);
        step();

        // Intra-pair WAW
        idle(); valA = 1; valB = 1; wrA = 1; wrB = 1; rdA = 7; rdB = 7;
        #1 chk("waw_issue", {30'd0, issue}, 32'h2);
        step();
        rdB = 8;
        #1 chk("nowaw_issue", {30'd0, issue}, 32'h3);
        step();

        // Set beats a same-cycle clear
        idle(); valA = 1; wrA = 1; longA = 1; rdA = 9; wbB = 1; wbRdB = 9;
        step();
        chk("setwins_busy9", {31'd0, busy[9]}, 32'd1);

        // Saturate the stall counter via hold
        idle(); valA = 1; hold = 1;
        chk_en = 0;
        for (int i = 0; i < 65536 + 3; i++) step();
        chk_en = 1;
        chk("sat_cnt", {16'd0, cnt}, 32'h0000FFFF);
        step();
        chk("sat_hold", {16'd0, cnt}, 32'h0000FFFF);

        // Reset mid-stall
        reset = 1;
        step();
        chk("midrst_busy", busy, 32'd0);
        chk("midrst_cnt", {16'd0, cnt}, 32'd0);
        reset = 0;
        idle();
        step();

        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            valA  = $urandom_range(0, 3) != 0;
            valB  = valA && ($urandom_range(0, 3) != 0);
            rs1A  = AW'($urandom_range(0, 7)); rs2A = AW'($urandom_range(0, 7));
            rs1B  = AW'($urandom_range(0, 7)); rs2B = AW'($urandom_range(0, 7));
            rdA   = AW'($urandom_range(0, 7)); rdB  = AW'($urandom_range(0, 7));
            wrA   = $urandom_range(0, 1); wrB = $urandom_range(0, 1);
            longA = $urandom_range(0, 1); longB = $urandom_range(0, 1);
            wbA   = $urandom_range(0, 2) == 0; wbB = $urandom_range(0, 2) == 0;
            wbRdA = AW'($urandom_range(0, 7)); wbRdB = AW'($urandom_range(0, 7));
            hold  = $urandom_range(0, 7) == 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
